// File: rtl/uop_queue_if.sv
// Handshake bundle between the instruction cracker, the micro-op queue and the renamer.
// The master side is the cracker/renamer pair; the slave side is the queue itself.
interface uop_queue_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4,
    parameter int IN_W  = 2,
    parameter int UOP_W = 24
);
    logic                           flush;
    logic [IN_W*UOP_W-1:0]          enq_uops;
    logic [IN_W-1:0]                enq_valid;
    logic                           enq_ready;
    logic [WIDTH*UOP_W-1:0]         deq_uops;
    logic [WIDTH-1:0]               deq_valid;
    logic [$clog2(WIDTH+1)-1:0]     deq_take;
    logic [$clog2(DEPTH+1)-1:0]     count;

    modport master (
        output flush, enq_uops, enq_valid, deq_take,
        input  enq_ready, deq_uops, deq_valid, count
    );

    modport slave (
        input  flush, enq_uops, enq_valid, deq_take,
        output enq_ready, deq_uops, deq_valid, count
    );
endinterface

// File: rtl/uop_queue.sv
// Circular micro-op buffer: up to IN_W micro-ops in per cycle, oldest WIDTH presented
// in program order, consumed prefix retired, single-cycle flush on redirect.
module uop_queue #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4,
    parameter int IN_W  = 2,
    parameter int UOP_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    uop_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] READY_MAX  = CNT_W'(DEPTH - IN_W);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [UOP_W-1:0] r_mem [DEPTH];

    logic [CNT_W-1:0] w_n_enq;
    logic [CNT_W-1:0] w_n_deq;
    logic [CNT_W-1:0] w_take;
    logic             w_run;
    logic             w_ready;
    logic             w_do_enq;
    logic             w_wr;

    // Only the leading run of valid slots counts; anything after the first gap is dropped.
    always_comb begin
        w_n_enq = '0;
        w_run   = 1'b1;
        for (int k = 0; k < IN_W; k++) begin
            if (w_run && q.enq_valid[k]) begin
                w_n_enq = w_n_enq + ONE_C;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_ready  = (r_count <= READY_MAX);
    assign w_do_enq = w_ready && (w_n_enq != '0);
    assign w_wr     = w_do_enq && !q.flush && !rst;
    assign w_take   = CNT_W'(q.deq_take);
    assign w_n_deq  = (w_take > r_count) ? r_count : w_take;

    assign q.enq_ready = w_ready;
    assign q.count     = r_count;

    // Dequeue window is purely a function of registered state; no enqueue bypass.
    always_comb begin
        q.deq_uops  = '0;
        q.deq_valid = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (r_count > CNT_W'(k)) begin
                q.deq_valid[k]               = 1'b1;
                q.deq_uops[k*UOP_W +: UOP_W] = r_mem[r_head + PTR_W'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head <= r_head + PTR_W'(w_n_deq);
            if (w_do_enq) begin
                r_tail  <= r_tail + PTR_W'(w_n_enq);
                r_count <= r_count + w_n_enq - w_n_deq;
            end else begin
                r_count <= r_count - w_n_deq;
            end
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int k = 0; k < IN_W; k++) begin
                if (CNT_W'(k) < w_n_enq) begin
                    r_mem[r_tail + PTR_W'(k)] <= q.enq_uops[k*UOP_W +: UOP_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_uop_queue.sv
// Directed bench for uop_queue: ordering, full, wrap, clamping and flush behaviour.
module tb_uop_queue;
    localparam int DEPTH = 16;
    localparam int WIDTH = 4;
    localparam int IN_W  = 2;
    localparam int UOP_W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    uop_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IN_W(IN_W), .UOP_W(UOP_W)) q();

    uop_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IN_W(IN_W), .UOP_W(UOP_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [23:0] u0, input logic [23:0] u1,
                         input logic [2:0] take, input logic fl);
        q.enq_valid = v;
        q.enq_uops  = {u1, u0};
        q.deq_take  = take;
        q.flush     = fl;
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with random inputs
        drive(2'($urandom), 24'($urandom), 24'($urandom), 3'($urandom_range(0, 4)), 1'($urandom));
        rst = 1'b1;
        tick();
        drive(2'($urandom), 24'($urandom), 24'($urandom), 3'($urandom_range(0, 4)), 1'($urandom));
        tick();
        rst = 1'b0;
        drive(2'b00, 24'h0, 24'h0, 3'd0, 1'b0);
        chk("rst_count", 96'(q.count), 96'd0);
        chk("rst_deq_valid", 96'(q.deq_valid), 96'd0);
        chk("rst_enq_ready", 96'(q.enq_ready), 96'd1);
        chk("rst_deq_uops", q.deq_uops, 96'd0);

        // Ordering
        drive(2'b11, 24'hA00123, 24'hB00456, 3'd0, 1'b0);
        tick();
        chk("ord_c1_valid", 96'(q.deq_valid), 96'b0011);
        chk("ord_c1_count", 96'(q.count), 96'd2);
        drive(2'b01, 24'hC00789, 24'hEEEEEE, 3'd0, 1'b0);
        tick();
        chk("ord_c2_valid", 96'(q.deq_valid), 96'b0111);
        chk("ord_c2_uops", q.deq_uops, 96'h000000_C00789_B00456_A00123);
        drive(2'b00, 24'h0, 24'h0, 3'd2, 1'b0);
        tick();
        chk("ord_take_slot0", 96'(q.deq_uops[23:0]), 96'hC00789);
        chk("ord_take_count", 96'(q.count), 96'd1);
        chk("ord_take_uops", q.deq_uops, 96'h000000_000000_000000_C00789);
        drive(2'b00, 24'h0, 24'h0, 3'd1, 1'b0);
        tick();
        chk("drain_count", 96'(q.count), 96'd0);
        drive(2'b10, 24'h111111, 24'h222222, 3'd0, 1'b0);
        tick();
        chk("gap_ignored_count", 96'(q.count), 96'd0);
        chk("empty_valid", 96'(q.deq_valid), 96'd0);

        // Full
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, 24'h100000 + 24'(2*i), 24'h100001 + 24'(2*i), 3'd0, 1'b0);
            tick();
        end
        chk("fill14_count", 96'(q.count), 96'd14);
        chk("fill14_ready", 96'(q.enq_ready), 96'd1);
        drive(2'b01, 24'h10000E, 24'h0, 3'd0, 1'b0);
        tick();
        chk("fill15_count", 96'(q.count), 96'd15);
        chk("fill15_ready", 96'(q.enq_ready), 96'd0);
        drive(2'b11, 24'hFFFFFF, 24'hFFFFFF, 3'd0, 1'b0);
        tick();
        chk("full_ignore_count", 96'(q.count), 96'd15);
        chk("full_slot0", 96'(q.deq_uops[23:0]), 96'h100000);
        drive(2'b00, 24'h0, 24'h0, 3'd4, 1'b0);
        tick();
        chk("full_take_count", 96'(q.count), 96'd11);
        chk("full_take_ready", 96'(q.enq_ready), 96'd1);
        chk("full_take_slot0", 96'(q.deq_uops[23:0]), 96'h100004);
        drive(2'b11, 24'h200000, 24'h200001, 3'd0, 1'b0);
        tick();
        drive(2'b01, 24'h200002, 24'h0, 3'd0, 1'b0);
        tick();
        drive(2'b11, 24'h200003, 24'h200004, 3'd0, 1'b0);
        tick();
        chk("fill16_count", 96'(q.count), 96'd16);
        chk("fill16_ready", 96'(q.enq_ready), 96'd0);
        chk("fill16_valid", 96'(q.deq_valid), 96'b1111);
        drive(2'b00, 24'h0, 24'h0, 3'd4, 1'b0);
        tick();
        chk("full16_take_count", 96'(q.count), 96'd12);
        chk("full16_take_ready", 96'(q.enq_ready), 96'd1);
        chk("full16_take_slot0", 96'(q.deq_uops[23:0]), 96'h100008);

        // Flush back to index 0, then walk head to 14
        drive(2'b00, 24'h0, 24'h0, 3'd0, 1'b1);
        tick();
        drive(2'b00, 24'h0, 24'h0, 3'd0, 1'b0);
        chk("flush12_count", 96'(q.count), 96'd0);
        chk("flush12_valid", 96'(q.deq_valid), 96'd0);
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, 24'h700000 + 24'(2*i), 24'h700001 + 24'(2*i), 3'd0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 24'h0, 24'h0, 3'd4, 1'b0);
            tick();
        end
        chk("walk_slot0", 96'(q.deq_uops[23:0]), 96'h70000C);
        drive(2'b00, 24'h0, 24'h0, 3'd2, 1'b0);
        tick();
        chk("walk_empty_count", 96'(q.count), 96'd0);
        drive(2'b00, 24'h0, 24'h0, 3'd4, 1'b0);
        tick();
        chk("empty_take_count", 96'(q.count), 96'd0);
        chk("empty_take_uops", q.deq_uops, 96'd0);

        // Wrap: entries land at 14, 15, 0, 1
        drive(2'b11, 24'h300000, 24'h300001, 3'd0, 1'b0);
        tick();
        drive(2'b11, 24'h300002, 24'h300003, 3'd0, 1'b0);
        tick();
        chk("wrap_count", 96'(q.count), 96'd4);
        chk("wrap_valid", 96'(q.deq_valid), 96'b1111);
        chk("wrap_uops", q.deq_uops, 96'h300003_300002_300001_300000);

        // Simultaneous enqueue and clamped dequeue
        drive(2'b00, 24'h0, 24'h0, 3'd1, 1'b0);
        tick();
        chk("sim_pre_count", 96'(q.count), 96'd3);
        drive(2'b11, 24'h400000, 24'h400001, 3'd4, 1'b0);
        tick();
        chk("sim_count", 96'(q.count), 96'd2);
        chk("sim_valid", 96'(q.deq_valid), 96'b0011);
        chk("sim_uops", q.deq_uops, 96'h000000_000000_400001_400000);

        // Flush mid-stream with enqueue active
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 24'h500000 + 24'(2*i), 24'h500001 + 24'(2*i), 3'd0, 1'b0);
            tick();
        end
        drive(2'b01, 24'h500006, 24'h0, 3'd0, 1'b0);
        tick();
        chk("pre_flush_count", 96'(q.count), 96'd9);
        drive(2'b11, 24'h5AAAAA, 24'h5BBBBB, 3'd2, 1'b1);
        tick();
        drive(2'b00, 24'h0, 24'h0, 3'd0, 1'b0);
        chk("flush_count", 96'(q.count), 96'd0);
        chk("flush_valid", 96'(q.deq_valid), 96'd0);
        chk("flush_ready", 96'(q.enq_ready), 96'd1);
        chk("flush_uops", q.deq_uops, 96'd0);
        tick();
        chk("post_flush_count", 96'(q.count), 96'd0);
        drive(2'b01, 24'h600000, 24'h0, 3'd0, 1'b0);
        tick();
        drive(2'b00, 24'h0, 24'h0, 3'd0, 1'b0);
        chk("post_flush_enq_count", 96'(q.count), 96'd1);
        chk("post_flush_enq_uops", q.deq_uops, 96'h000000_000000_000000_600000);

        // Reset outranks a concurrent enqueue
        drive(2'b11, 24'h800000, 24'h800001, 3'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(2'b00, 24'h0, 24'h0, 3'd0, 1'b0);
        chk("rst2_count", 96'(q.count), 96'd0);
        chk("rst2_valid", 96'(q.deq_valid), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
